// File: rtl/lsq_commit_if.sv
// Interface bundling the decode, CDB, ROB commit, memory and result buses
// of the load/store queue.
//   slave  : the queue's view (decode/CDB/commit/memory inputs; ready, memory request, result outputs)
//   master : the surrounding pipeline's view (directions reversed)
// rdy and flush travel with the bus because every producer needs to see them.
interface lsq_commit_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) ();
  logic              rdy;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [3:0]        alloc_op;
  logic [DATA_W-1:0] alloc_v1;
  logic [TAG_W-1:0]  alloc_t1;
  logic [DATA_W-1:0] alloc_v2;
  logic [TAG_W-1:0]  alloc_t2;
  logic [DATA_W-1:0] alloc_imm;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_value;

  modport slave (
    input  rdy, flush,
    input  alloc_valid, alloc_tag, alloc_op, alloc_v1, alloc_t1, alloc_v2, alloc_t2, alloc_imm,
    input  cdb_valid, cdb_tag, cdb_value,
    input  commit_valid, commit_tag,
    input  mem_done, mem_rdata,
    output alloc_ready,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output res_valid, res_tag, res_value
  );

  modport master (
    output rdy, flush,
    output alloc_valid, alloc_tag, alloc_op, alloc_v1, alloc_t1, alloc_v2, alloc_t2, alloc_imm,
    output cdb_valid, cdb_tag, cdb_value,
    output commit_valid, commit_tag,
    output mem_done, mem_rdata,
    input  alloc_ready,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  res_valid, res_tag, res_value
  );
endinterface

// File: rtl/lsq_commit.sv
// In-order load/store queue between decode/ROB and the memory controller.
// Entries snoop the CDB for their operands, compute addresses, report ready
// stores to the ROB, and go to memory strictly from the head; stores go only
// once committed. A flush keeps the committed stores at the head.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsq_commit_if.slave (rdy/flush, alloc, CDB, commit, memory, result)
// TAG_W/DATA_W must match the connected interface instance.
module lsq_commit #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  lsq_commit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DRAIN} state_t;

  typedef struct packed {
    logic              valid;
    logic              store;
    logic              uns;
    logic [1:0]        size;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] addr;
    logic              addr_rdy;
    logic              reported;
    logic              committed;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  state_t            state;

  logic [CNT_W-1:0]  keep;
  logic [PTR_W-1:0]  kc_idx;
  logic              kc_run;
  logic [DEPTH-1:0]  kept;
  logic [PTR_W-1:0]  kd_dist;
  logic              rep_found;
  logic [PTR_W-1:0]  rep_idx;
  logic [PTR_W-1:0]  rs_idx;
  logic [DATA_W-1:0] ld_ext;
  entry_t            new_ent;
  logic              push;
  logic              pop;
  logic              ld_done;
  logic              st_done;

  assign push    = bus.alloc_valid && (count != CNT_W'(DEPTH));
  assign ld_done = bus.mem_done && (state == S_LOAD);
  assign st_done = bus.mem_done && (state == S_STORE);
  assign pop     = ld_done || st_done;

  // Number of committed stores forming an unbroken run from the head.
  always_comb begin
    keep   = '0;
    kc_run = 1'b1;
    kc_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      kc_idx = head + PTR_W'(i);
      if (kc_run && q[kc_idx].valid && q[kc_idx].store && q[kc_idx].committed)
        keep = keep + CNT_W'(1);
      else
        kc_run = 1'b0;
    end
  end

  // Slots that survive a flush: the first 'keep' slots counted from head.
  always_comb begin
    kept    = '0;
    kd_dist = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      kd_dist = PTR_W'(i) - head;
      kept[i] = ({1'b0, kd_dist} < keep);
    end
  end

  // Oldest store with address and data ready that has not been reported.
  always_comb begin
    rep_found = 1'b0;
    rep_idx   = '0;
    rs_idx    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rs_idx = head + PTR_W'(i);
      if (!rep_found && q[rs_idx].valid && q[rs_idx].store && q[rs_idx].addr_rdy &&
          (q[rs_idx].t2 == '0) && !q[rs_idx].reported) begin
        rep_found = 1'b1;
        rep_idx   = rs_idx;
      end
    end
  end

  // Load data extension by size and signedness of the head entry.
  always_comb begin
    case (q[head].size)
      2'd0:    ld_ext = q[head].uns ? DATA_W'(bus.mem_rdata[7:0])
                                    : {{(DATA_W-8){bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      2'd1:    ld_ext = q[head].uns ? DATA_W'(bus.mem_rdata[15:0])
                                    : {{(DATA_W-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Incoming entry, capturing a same-cycle CDB broadcast for either operand.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.store = bus.alloc_op[3];
    new_ent.uns   = bus.alloc_op[2];
    new_ent.size  = bus.alloc_op[1:0];
    new_ent.tag   = bus.alloc_tag;
    new_ent.v1    = bus.alloc_v1;
    new_ent.t1    = bus.alloc_t1;
    new_ent.v2    = bus.alloc_v2;
    new_ent.t2    = bus.alloc_t2;
    new_ent.imm   = bus.alloc_imm;
    if (bus.cdb_valid && (bus.alloc_t1 != '0) && (bus.alloc_t1 == bus.cdb_tag)) begin
      new_ent.v1 = bus.cdb_value;
      new_ent.t1 = '0;
    end
    if (bus.cdb_valid && (bus.alloc_t2 != '0) && (bus.alloc_t2 == bus.cdb_tag)) begin
      new_ent.v2 = bus.cdb_value;
      new_ent.t2 = '0;
    end
  end

  // Queue state, memory-side state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      state           <= S_IDLE;
      bus.alloc_ready <= 1'b1;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_size    <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_tag     <= '0;
      bus.res_value   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
    end else if (bus.rdy) begin
      bus.res_valid <= 1'b0;
      if (bus.flush) begin
        // Committed head run survives; an in-flight store still retires.
        for (int i = 0; i < int'(DEPTH); i++)
          if (!kept[i]) q[i].valid <= 1'b0;
        if (st_done) begin
          q[head].valid <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        tail            <= head + keep[PTR_W-1:0];
        count           <= keep - CNT_W'(st_done);
        bus.alloc_ready <= (keep - CNT_W'(st_done)) != CNT_W'(DEPTH);
        case (state)
          S_LOAD: begin
            if (bus.mem_done) begin
              state       <= S_IDLE;
              bus.mem_req <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end
          S_STORE, S_DRAIN: begin
            if (bus.mem_done) begin
              state       <= S_IDLE;
              bus.mem_req <= 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (q[i].valid) begin
            if (!q[i].addr_rdy && (q[i].t1 == '0)) begin
              q[i].addr     <= q[i].v1 + q[i].imm;
              q[i].addr_rdy <= 1'b1;
            end
            if (bus.cdb_valid && (q[i].t1 != '0) && (q[i].t1 == bus.cdb_tag)) begin
              q[i].v1 <= bus.cdb_value;
              q[i].t1 <= '0;
            end
            if (bus.cdb_valid && (q[i].t2 != '0) && (q[i].t2 == bus.cdb_tag)) begin
              q[i].v2 <= bus.cdb_value;
              q[i].t2 <= '0;
            end
            if (bus.commit_valid && q[i].store && (q[i].tag == bus.commit_tag))
              q[i].committed <= 1'b1;
          end
        end

        // Load data wins the result port; a store report waits a cycle.
        if (ld_done) begin
          bus.res_valid <= 1'b1;
          bus.res_tag   <= q[head].tag;
          bus.res_value <= ld_ext;
        end else if (rep_found) begin
          bus.res_valid        <= 1'b1;
          bus.res_tag          <= q[rep_idx].tag;
          bus.res_value        <= '0;
          q[rep_idx].reported  <= 1'b1;
        end

        case (state)
          S_IDLE: begin
            if (q[head].valid && !q[head].store && q[head].addr_rdy) begin
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= 1'b0;
              bus.mem_size <= q[head].size;
              bus.mem_addr <= q[head].addr;
              state        <= S_LOAD;
            end else if (q[head].valid && q[head].store && q[head].committed &&
                         q[head].addr_rdy && (q[head].t2 == '0)) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_size  <= q[head].size;
              bus.mem_addr  <= q[head].addr;
              bus.mem_wdata <= q[head].v2;
              state         <= S_STORE;
            end
          end
          S_LOAD, S_STORE, S_DRAIN: begin
            if (bus.mem_done) begin
              bus.mem_req <= 1'b0;
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase

        if (pop) begin
          q[head].valid <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        if (push) begin
          q[tail] <= new_ent;
          tail    <= tail + PTR_W'(1);
        end
        count           <= count + CNT_W'(push) - CNT_W'(pop);
        bus.alloc_ready <= (count + CNT_W'(push) - CNT_W'(pop)) != CNT_W'(DEPTH);
      end
    end
  end

endmodule

// File: tb/tb_lsq_commit.sv
// Self-checking bench for lsq_commit: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based behavioural model of the load/store queue.
module tb_lsq_commit;
  localparam int DEPTH = 16;
  localparam int K_IDLE = 0, K_LOAD = 1, K_STORE = 2, K_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsq_commit_if #(.TAG_W(4), .DATA_W(32)) bus ();
  lsq_commit #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        st;
    bit        uns;
    bit [1:0]  size;
    bit [3:0]  tag;
    bit [31:0] v1;
    bit [3:0]  t1;
    bit [31:0] v2;
    bit [3:0]  t2;
    bit [31:0] imm;
    bit [31:0] addr;
    bit        ardy;
    bit        rep;
    bit        com;
  } ment_t;

  ment_t     mq[$];
  int        kind;
  bit        e_ready, e_req, e_we, e_rv;
  bit [1:0]  e_size;
  bit [31:0] e_addr, e_wdata, e_rval;
  bit [3:0]  e_rt;
  int        n_cmp = 0;
  int        n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] mext(bit [31:0] r, bit [1:0] sz, bit u);
    bit [31:0] v;
    if (sz == 0) begin
      v = r % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = r % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Next-cycle expectation from the inputs currently on the bus.
  task automatic model_step();
    ment_t nq[$];
    ment_t n;
    bit ld_done, pop, found;
    int keep;
    if (rst) begin
      mq.delete();
      kind = K_IDLE;
      e_req = 0; e_we = 0; e_size = 0; e_addr = 0; e_wdata = 0;
      e_rv = 0; e_rt = 0; e_rval = 0; e_ready = 1;
      return;
    end
    if (!bus.rdy) return;
    ld_done = (kind == K_LOAD) && bus.mem_done;
    pop = ((kind == K_LOAD) || (kind == K_STORE)) && bus.mem_done;
    e_rv = 0;
    if (bus.flush) begin
      keep = 0;
      while (keep < mq.size() && mq[keep].st && mq[keep].com) keep++;
      while (mq.size() > keep) void'(mq.pop_back());
      if (kind == K_STORE && bus.mem_done) void'(mq.pop_front());
      if (bus.mem_done && kind != K_IDLE) begin
        kind = K_IDLE;
        e_req = 0;
      end else if (kind == K_LOAD) begin
        kind = K_DRAIN;
      end
    end else begin
      nq = mq;
      foreach (mq[i]) begin
        if (mq[i].t1 == 0 && !mq[i].ardy) begin
          nq[i].addr = mq[i].v1 + mq[i].imm;
          nq[i].ardy = 1;
        end
        if (bus.cdb_valid && mq[i].t1 != 0 && mq[i].t1 == bus.cdb_tag) begin
          nq[i].v1 = bus.cdb_value; nq[i].t1 = 0;
        end
        if (bus.cdb_valid && mq[i].t2 != 0 && mq[i].t2 == bus.cdb_tag) begin
          nq[i].v2 = bus.cdb_value; nq[i].t2 = 0;
        end
        if (bus.commit_valid && mq[i].st && mq[i].tag == bus.commit_tag) nq[i].com = 1;
      end
      if (ld_done) begin
        e_rv = 1; e_rt = mq[0].tag; e_rval = mext(bus.mem_rdata, mq[0].size, mq[0].uns);
      end else begin
        found = 0;
        foreach (mq[i])
          if (!found && mq[i].st && mq[i].ardy && mq[i].t2 == 0 && !mq[i].rep) begin
            found = 1; nq[i].rep = 1; e_rv = 1; e_rt = mq[i].tag; e_rval = 0;
          end
      end
      if (kind == K_IDLE) begin
        if (mq.size() > 0 && !mq[0].st && mq[0].ardy) begin
          e_req = 1; e_we = 0; e_size = mq[0].size; e_addr = mq[0].addr; kind = K_LOAD;
        end else if (mq.size() > 0 && mq[0].st && mq[0].com && mq[0].ardy && mq[0].t2 == 0) begin
          e_req = 1; e_we = 1; e_size = mq[0].size; e_addr = mq[0].addr;
          e_wdata = mq[0].v2; kind = K_STORE;
        end
      end else if (bus.mem_done) begin
        e_req = 0; kind = K_IDLE;
      end
      if (pop) void'(nq.pop_front());
      if (bus.alloc_valid && mq.size() != DEPTH) begin
        n = '{default: 0};
        n.st = bus.alloc_op[3]; n.uns = bus.alloc_op[2]; n.size = bus.alloc_op[1:0];
        n.tag = bus.alloc_tag; n.v1 = bus.alloc_v1; n.t1 = bus.alloc_t1;
        n.v2 = bus.alloc_v2; n.t2 = bus.alloc_t2; n.imm = bus.alloc_imm;
        if (bus.cdb_valid && n.t1 != 0 && n.t1 == bus.cdb_tag) begin n.v1 = bus.cdb_value; n.t1 = 0; end
        if (bus.cdb_valid && n.t2 != 0 && n.t2 == bus.cdb_tag) begin n.v2 = bus.cdb_value; n.t2 = 0; end
        nq.push_back(n);
      end
      mq = nq;
    end
    e_ready = (mq.size() != DEPTH);
  endtask

  task automatic compare();
    check("alloc_ready", bus.alloc_ready, e_ready);
    check("mem_req", bus.mem_req, e_req);
    if (e_req) begin
      check("mem_we", bus.mem_we, e_we);
      check("mem_size", bus.mem_size, e_size);
      check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
    end
    check("res_valid", bus.res_valid, e_rv);
    if (e_rv) begin
      check("res_tag", bus.res_tag, e_rt);
      check("res_value", bus.res_value, e_rval);
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clr();
    bus.rdy = 1; bus.flush = 0;
    bus.alloc_valid = 0; bus.alloc_tag = 0; bus.alloc_op = 0;
    bus.alloc_v1 = 0; bus.alloc_t1 = 0; bus.alloc_v2 = 0; bus.alloc_t2 = 0; bus.alloc_imm = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
    bus.commit_valid = 0; bus.commit_tag = 0;
    bus.mem_done = 0; bus.mem_rdata = 0;
  endtask

  task automatic alloc(input bit [3:0] tag, input bit [3:0] op, input bit [31:0] v1,
                       input bit [3:0] t1, input bit [31:0] v2, input bit [3:0] t2,
                       input bit [31:0] imm);
    bus.alloc_valid = 1; bus.alloc_tag = tag; bus.alloc_op = op;
    bus.alloc_v1 = v1; bus.alloc_t1 = t1; bus.alloc_v2 = v2; bus.alloc_t2 = t2;
    bus.alloc_imm = imm;
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 30 && !e_req; k++) step();
    check({name, "_req"}, bus.mem_req, 1);
  endtask

  task automatic do_load(input string name, input bit [3:0] tag, input bit [3:0] op,
                         input bit [31:0] base, input bit [31:0] imm,
                         input bit [31:0] rdata, input bit [31:0] expv);
    clr(); alloc(tag, op, base, 0, 0, 0, imm); step(); clr();
    wait_req(name);
    check({name, "_addr"}, bus.mem_addr, base + imm);
    check({name, "_we"}, bus.mem_we, 0);
    check({name, "_size"}, bus.mem_size, {30'd0, op[1:0]});
    bus.mem_done = 1; bus.mem_rdata = rdata; step(); clr();
    check({name, "_rv"}, bus.res_valid, 1);
    check({name, "_rtag"}, bus.res_tag, {28'd0, tag});
    check({name, "_rval"}, bus.res_value, expv);
    check({name, "_reqoff"}, bus.mem_req, 0);
  endtask

  task automatic drain_all(input string name);
    for (int k = 0; k < 800 && (mq.size() > 0 || e_req); k++) begin
      clr();
      bus.mem_done = e_req && ($urandom % 2 == 0);
      bus.mem_rdata = $urandom;
      bus.cdb_valid = ($urandom % 2 == 0);
      bus.cdb_tag = 4'($urandom_range(1, 15));
      bus.cdb_value = $urandom % 4096;
      step();
    end
    clr();
    check({name, "_empty"}, mq.size() + int'(e_req), 0);
    check({name, "_ready"}, bus.alloc_ready, 1);
  endtask

  task automatic rand_inputs();
    bus.rdy = ($urandom % 8) != 0;
    bus.flush = ($urandom % 40) == 0;
    bus.alloc_valid = $urandom % 2;
    bus.alloc_tag = 4'($urandom_range(1, 15));
    bus.alloc_op = {1'($urandom), 1'($urandom), 2'($urandom_range(0, 2))};
    bus.alloc_v1 = $urandom % 65536;
    bus.alloc_t1 = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    bus.alloc_v2 = $urandom;
    bus.alloc_t2 = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    bus.alloc_imm = $urandom % 256;
    bus.cdb_valid = $urandom % 2;
    bus.cdb_tag = 4'($urandom_range(1, 15));
    bus.cdb_value = $urandom;
    bus.commit_valid = ($urandom % 4) == 0;
    bus.commit_tag = 4'($urandom_range(1, 15));
    bus.mem_done = e_req && ($urandom % 3 == 0);
    bus.mem_rdata = $urandom;
  endtask

  initial begin
    int nrep, nreq, nres;
    clr();
    rst = 1;
    step(); step();
    rst = 0;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_alloc_ready", bus.alloc_ready, 1);

    // Loads with every extension flavour.
    do_load("lw", 4'd3, 4'b0010, 32'h100, 32'h4, 32'hDEADBEEF, 32'hDEADBEEF);
    check("lw_count", mq.size(), 0);
    do_load("lb", 4'd4, 4'b0000, 32'h10, 32'h0, 32'h0000_0080, 32'hFFFF_FF80);
    do_load("lbu", 4'd5, 4'b0100, 32'h10, 32'h1, 32'h0000_0080, 32'h0000_0080);
    do_load("lh", 4'd6, 4'b0001, 32'h20, 32'h2, 32'h0000_8001, 32'hFFFF_8001);

    // Store waits on CDB operands, reports once, writes only after commit.
    clr(); alloc(4'd5, 4'b1010, 0, 4'd2, 0, 4'd4, 0); step(); clr();
    step(); step();
    nrep = 0; nreq = 0;
    for (int k = 0; k < 10; k++) begin
      clr();
      if (k == 0) begin bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_value = 32'h200; end
      if (k == 1) begin bus.cdb_valid = 1; bus.cdb_tag = 4; bus.cdb_value = 32'h55; end
      step();
      if (bus.res_valid && bus.res_tag == 4'd5) nrep++;
      if (bus.mem_req) nreq++;
    end
    check("sw_reports", nrep, 1);
    check("sw_no_req_before_commit", nreq, 0);
    clr(); bus.commit_valid = 1; bus.commit_tag = 5; step(); clr();
    wait_req("sw");
    check("sw_we", bus.mem_we, 1);
    check("sw_addr", bus.mem_addr, 32'h200);
    check("sw_wdata", bus.mem_wdata, 32'h55);
    check("sw_size", bus.mem_size, 2);
    bus.mem_done = 1; step(); clr();
    check("sw_reqoff", bus.mem_req, 0);

    // Fill, overflow attempt, pop with simultaneous alloc, pointer wrap.
    for (int k = 0; k < DEPTH; k++) begin
      clr(); alloc(4'((k % 15) + 1), 4'b0010, 32'h1000, 4'd7, 0, 0, 32'(4 * k)); step();
    end
    clr();
    check("full_ready", bus.alloc_ready, 0);
    alloc(4'd9, 4'b0010, 32'h500, 0, 0, 0, 0); step(); clr();
    check("full_ignore_ready", bus.alloc_ready, 0);
    check("full_ignore_count", mq.size(), DEPTH);
    bus.cdb_valid = 1; bus.cdb_tag = 7; bus.cdb_value = 32'h40; step(); clr();
    wait_req("fill1");
    alloc(4'd9, 4'b0010, 32'h500, 0, 0, 0, 0); bus.mem_done = 1; bus.mem_rdata = 32'h11; step(); clr();
    check("fill_pop_rv", bus.res_valid, 1);
    check("fill_pop_ready", bus.alloc_ready, 1);
    wait_req("fill2");
    alloc(4'd10, 4'b0010, 32'h600, 0, 0, 0, 0); bus.mem_done = 1; bus.mem_rdata = 32'h22; step(); clr();
    check("fill_swap_ready", bus.alloc_ready, 1);
    alloc(4'd11, 4'b0010, 32'h700, 0, 0, 0, 0); step(); clr();
    check("fill_refull_ready", bus.alloc_ready, 0);
    drain_all("fill_drain");

    // Flush keeps the committed head store, drops the loads behind it.
    clr(); alloc(4'd5, 4'b1010, 32'h300, 0, 32'h77, 0, 0); step();
    clr(); alloc(4'd6, 4'b0010, 32'h40, 0, 0, 0, 0); step();
    clr(); alloc(4'd7, 4'b0010, 32'h44, 0, 0, 0, 0); step(); clr();
    for (int k = 0; k < 4; k++) step();
    bus.commit_valid = 1; bus.commit_tag = 5; step(); clr();
    bus.flush = 1; step(); clr();
    check("flush_keep_count", mq.size(), 1);
    wait_req("flush_st");
    check("flush_st_we", bus.mem_we, 1);
    check("flush_st_addr", bus.mem_addr, 32'h300);
    check("flush_st_wdata", bus.mem_wdata, 32'h77);
    bus.mem_done = 1; step(); clr();
    nres = 0;
    for (int k = 0; k < 8; k++) begin step(); if (bus.res_valid) nres++; end
    check("flush_no_results", nres, 0);
    check("flush_ready", bus.alloc_ready, 1);

    // Flush during an outstanding load drains it silently.
    clr(); alloc(4'd8, 4'b0010, 32'h40, 0, 0, 0, 0); step(); clr();
    wait_req("drain");
    bus.flush = 1; step(); clr();
    check("drain_hold_req", bus.mem_req, 1);
    step(); step();
    bus.mem_done = 1; bus.mem_rdata = 32'hABCD; step(); clr();
    check("drain_no_res", bus.res_valid, 0);
    check("drain_reqoff", bus.mem_req, 0);
    do_load("after_flush", 4'd9, 4'b0010, 32'h80, 32'h8, 32'h1234, 32'h1234);

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      rst = (c == 2000 || c == 2001);
      step();
    end
    rst = 0;
    clr(); bus.flush = 1; step();
    drain_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/lsq_commit.md
Name: lsq_commit
Overview:
- Parametrised in-order load/store queue sitting between decode/ROB and the memory controller.
- Resolves operands from the CDB and computes effective addresses.
- Reports store readiness to the ROB and issues stores to memory only after ROB commit.
- Sign/zero-extends load data. On flush, keeps committed-but-unwritten stores and discards everything else.

Parameters:
DEPTH, 16, queue entries (power of 2, >=2)
TAG_W, 4, ROB tag width; tag 0 = "no tag / value ready"
DATA_W, 32, data and address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0, all state holds and outputs hold
flush  in  1  misprediction flush
alloc_valid  in  1  new entry from decode
alloc_ready  out  1  queue not full
alloc_tag  in  TAG_W  ROB tag of entry (nonzero)
alloc_op  in  4  [3]=store, [2]=unsigned (loads), [1:0]=size 0:B 1:H 2:W
alloc_v1/alloc_t1  in  DATA_W/TAG_W  base value/tag
alloc_v2/alloc_t2  in  DATA_W/TAG_W  store data value/tag
alloc_imm  in  DATA_W  offset
cdb_valid/cdb_tag/cdb_value  in  1/TAG_W/DATA_W  result broadcast snooped
commit_valid/commit_tag  in  1/TAG_W  ROB commits a store
mem_req  out  1  request, held until mem_done
mem_we  out  1  1=write
mem_size  out  2  as op[1:0]
mem_addr/mem_wdata  out  DATA_W  address/store data
mem_done  in  1  one-cycle completion pulse
mem_rdata  in  DATA_W  raw read data, LSB-aligned, valid with mem_done
res_valid/res_tag/res_value  out  1/TAG_W/DATA_W  load result, or store-ready report (value 0)

Behaviour:
- Reset: head=tail=count=0; all entries invalid; state IDLE; mem_req=0, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0, res_valid=0, res_tag=0, res_value=0.
- Circular buffer with pointer wrap modulo DEPTH.
  - alloc_ready = (count != DEPTH).
  - Allocation happens on alloc_valid && alloc_ready; alloc_valid while full is ignored.
- Operand capture:
  - A tag equal to cdb_tag with cdb_valid, same cycle as alloc, is captured as a ready value.
  - Every valid entry snoops the CDB each cycle.
- Address: any entry with base ready and address not yet ready latches addr = v1+imm (mod 2^DATA_W) the next cycle; all such entries update in parallel.
- Store-ready report:
  - Applies to a store with address ready, data ready and not yet reported; the oldest such store is selected.
  - Drives res_valid=1, res_tag=tag for 1 cycle and sets its reported bit.
  - A load result has priority; a blocked report retries the next cycle.
- Commit: commit_valid && tag matches a valid store sets committed=1. A commit matching no entry is ignored.
- State machine:
  - IDLE:
    - Head load with address ready: issue read (mem_req=1, we=0) next cycle -> LOAD.
    - Head store that is committed: issue write with addr/data/size -> STORE.
  - LOAD, on mem_done:
    - Extend rdata by size and unsigned bit.
    - Next cycle res_valid=1, res_tag, res_value.
    - Pop head; mem_req=0 -> IDLE.
  - STORE, on mem_done: pop head, mem_req=0 -> IDLE.
  - DRAIN: mem_req held until mem_done; data discarded; no result -> IDLE.
- mem_* signals are stable while mem_req=1. Back-to-back requests need at least one IDLE cycle.
- count updates correctly on simultaneous alloc and pop.
- Flush (priority over alloc, commit and CDB that cycle):
  - Committed stores are contiguous from head and are retained.
  - tail = head + committed_count; all other entries are invalidated; res_valid=0 next cycle.
  - In LOAD: go to DRAIN.
  - In STORE: the store is committed and completes normally.
- Reset mid-transaction: abandon immediately; mem_req=0 next cycle.

Test Plan:
- Alloc LW tag 3, base 0x100 ready, imm 4 -> mem_req with addr 0x104, size 2; mem_done with rdata 0xDEADBEEF -> res_tag 3, value 0xDEADBEEF the next cycle; count returns to 0.
- LB and LBU, rdata 0x00000080 -> values 0xFFFFFF80 and 0x00000080; LH with 0x8001 -> 0xFFFF8001.
- SW tag 5, base tag 2, data tag 4; CDB tag 2=0x200, then tag 4=0x55 -> one report res_tag 5; no mem_req until commit tag 5; then write addr 0x200, wdata 0x55.
- Fill DEPTH entries -> alloc_ready=0; 17th alloc ignored; pop and alloc in same cycle -> count stays DEPTH-1+1, pointers wrap.
- Committed SW at head, 2 loads behind it, flush -> count=1, store still written, no load results.
- Flush during an outstanding load -> DRAIN; mem_done produces no res_valid; new alloc after flush issues normally.
